// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared pipeline constants: default field widths, the control-word value a
// bubble presents downstream, a default-width entry struct and a helper that
// computes the flattened payload width from the field widths.
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  localparam int PIPE_PC_W    = 16;
  localparam int PIPE_INSTR_W = 16;
  localparam int PIPE_CW_W    = 8;
  localparam int PIPE_DATA_W  = 16;
  localparam int PIPE_NOPD    = 3;
  localparam int PIPE_DEST_W  = 3;

  // Control word carried by an empty slot; all-zero means "do nothing".
  localparam logic [PIPE_CW_W-1:0] CW_NOP = '0;

  // One pipeline entry at the default widths.
  typedef struct packed {
    logic [PIPE_PC_W-1:0]             pc;
    logic [PIPE_INSTR_W-1:0]          instr;
    logic [PIPE_CW_W-1:0]             cw;
    logic [PIPE_NOPD*PIPE_DATA_W-1:0] opd;
    logic [PIPE_DEST_W-1:0]           dest;
    logic                             hist;
  } pipe_entry_t;

  // Total bits held per entry: pc, instr, cw, operands, dest, history bit.
  function automatic int payload_width(input int pc_w, input int instr_w,
                                       input int cw_w, input int data_w,
                                       input int nopd, input int dest_w);
    return pc_w + instr_w + cw_w + nopd * data_w + dest_w + 1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready handshake plus pipeline payload for one side of a stage.
//   valid  : entry present            (master -> slave)
//   ready  : slave accepts this cycle (slave -> master)
//   pc, instr, cw, opd, dest, hist : payload (master -> slave)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int PC_W    = PIPE_PC_W,
  parameter int INSTR_W = PIPE_INSTR_W,
  parameter int CW_W    = PIPE_CW_W,
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int NOPD    = PIPE_NOPD,
  parameter int DEST_W  = PIPE_DEST_W
);

  logic                     valid;
  logic                     ready;
  logic [PC_W-1:0]          pc;
  logic [INSTR_W-1:0]       instr;
  logic [CW_W-1:0]          cw;
  logic [NOPD*DATA_W-1:0]   opd;
  logic [DEST_W-1:0]        dest;
  logic                     hist;

  modport master (
    output valid, pc, instr, cw, opd, dest, hist,
    input  ready
  );

  modport slave (
    input  valid, pc, instr, cw, opd, dest, hist,
    output ready
  );

endinterface

// File: rtl/pipe_stage_reg_payload.sv
// ---------------------------------------------------------------------------
// pipe_payload_reg
// One flattened payload register with load enable.
//   clk   : rising-edge clock
//   clr_n : synchronous active-low clear, zeroes the stored payload
//   load  : capture d on this edge
//   d / q : payload in / stored payload out
// ---------------------------------------------------------------------------
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register. With SKID=1 it holds up to two entries
// (main + skid) and in_ready is registered; with SKID=0 it holds one entry and
// in_ready is combinational from the downstream ready.
//   clk       : rising-edge clock
//   clr_n     : synchronous active-low reset (beats flush and transfers)
//   flush     : synchronous kill of every held entry and of any offered entry
//   in_bus    : upstream handshake + payload (slave side)
//   out_bus   : downstream handshake + payload (master side), driven from main
//   occupancy : number of held entries
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int PC_W    = PIPE_PC_W,
  parameter int INSTR_W = PIPE_INSTR_W,
  parameter int CW_W    = PIPE_CW_W,
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int NOPD    = PIPE_NOPD,
  parameter int DEST_W  = PIPE_DEST_W,
  parameter int SKID    = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  pipe_stage_reg_if.slave   in_bus,
  pipe_stage_reg_if.master  out_bus,
  output logic [1:0]        occupancy
);

  localparam int OPD_W = NOPD * DATA_W;
  localparam int PAY_W = payload_width(PC_W, INSTR_W, CW_W, DATA_W, NOPD, DEST_W);

  logic [PAY_W-1:0] in_payload;
  logic [PAY_W-1:0] main_d;
  logic [PAY_W-1:0] main_q;
  logic             main_load;
  logic             main_valid_reg;
  logic             in_ready;
  logic             accept;
  logic             issue;

  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [CW_W-1:0]    main_cw;
  logic [OPD_W-1:0]   main_opd;
  logic [DEST_W-1:0]  main_dest;
  logic               main_hist;

  assign in_payload = {in_bus.pc, in_bus.instr, in_bus.cw, in_bus.opd,
                       in_bus.dest, in_bus.hist};

  assign accept = in_bus.valid & in_ready;
  assign issue  = main_valid_reg & out_bus.ready;

  pipe_payload_reg #(.W(PAY_W)) u_main (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_valid_reg;
      logic             skid_valid_next;
      logic             main_valid_next;
      logic             skid_load;
      logic             main_from_skid;
      logic [PAY_W-1:0] skid_q;

      pipe_payload_reg #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (skid_load),
        .d     (in_payload),
        .q     (skid_q)
      );

      // Main always holds the oldest entry; skid only fills when main is
      // busy and not draining. Flush suppresses every load so an entry
      // offered on the flush edge leaves no trace.
      always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_load       = 1'b0;
        skid_load       = 1'b0;
        main_from_skid  = 1'b0;
        if (flush) begin
          main_valid_next = 1'b0;
          skid_valid_next = 1'b0;
        end else if (issue) begin
          if (skid_valid_reg) begin
            main_load       = 1'b1;
            main_from_skid  = 1'b1;
            main_valid_next = 1'b1;
            skid_load       = accept;
            skid_valid_next = accept;
          end else begin
            main_load       = accept;
            main_valid_next = accept;
          end
        end else if (main_valid_reg) begin
          if (accept) begin
            skid_load       = 1'b1;
            skid_valid_next = 1'b1;
          end
        end else if (accept) begin
          main_load       = 1'b1;
          main_valid_next = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          main_valid_reg <= 1'b0;
          skid_valid_reg <= 1'b0;
        end else begin
          main_valid_reg <= main_valid_next;
          skid_valid_reg <= skid_valid_next;
        end
      end

      // Straight from a flop: upstream never sees a combinational path.
      assign in_ready  = ~skid_valid_reg;
      assign main_d    = main_from_skid ? skid_q : in_payload;
      assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
    end else begin : g_single
      assign in_ready  = ~main_valid_reg | out_bus.ready;
      assign main_load = accept & ~flush;
      assign main_d    = in_payload;
      assign occupancy = {1'b0, main_valid_reg};

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          main_valid_reg <= 1'b0;
        end else if (flush) begin
          main_valid_reg <= 1'b0;
        end else if (accept) begin
          main_valid_reg <= 1'b1;
        end else if (issue) begin
          main_valid_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign {main_pc, main_instr, main_cw, main_opd, main_dest, main_hist} = main_q;

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = main_valid_reg;
  assign out_bus.pc    = main_pc;
  assign out_bus.instr = main_instr;
  assign out_bus.dest  = main_dest;
  // An empty slot must look like a NOP downstream, whatever main still holds.
  assign out_bus.cw    = main_valid_reg ? main_cw : CW_W'(CW_NOP);
  assign out_bus.hist  = main_valid_reg & main_hist;

  for (genvar gi = 0; gi < NOPD; gi++) begin : g_opd_lane
    assign out_bus.opd[gi*DATA_W +: DATA_W] = main_opd[gi*DATA_W +: DATA_W];
  end

endmodule
